// File: rtl/ifu_axi_prefetch.sv
// ifu_axi_prefetch: instruction-fetch AXI4-Lite read master.
// Accepts fetch addresses, keeps up to DEPTH reads in flight or buffered, and
// returns instruction words in order through a small response FIFO. A flush
// pulse empties the FIFO and marks every read still in flight for discard.
// Write channels are present only for bus uniformity and are tied idle.
// Optional build macro: IFU_PERF_EN adds internal 64-bit performance counters
// and an end-of-simulation summary; ports and timing are unchanged.
module ifu_axi_prefetch #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic                flush,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_data,
   output logic                resp_err,
   output logic [ADDR_W-1:0]   awaddr,
   output logic                awvalid,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wvalid,
   output logic                bready,
   input  logic                awready,
   input  logic                wready,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic [ADDR_W-1:0]   araddr,
   output logic                arvalid,
   input  logic                arready,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp,
   input  logic                rvalid,
   output logic                rready
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W:0]   CRED_MAX = (CNT_W+1)'(DEPTH);

   // Control state: reads in flight, reads to drop after a flush, FIFO fill.
   logic [CNT_W-1:0] out_cnt;
   logic [CNT_W-1:0] out_nxt;
   logic [CNT_W-1:0] disc_cnt;
   logic [CNT_W-1:0] fifo_cnt;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W:0]   credits;

   // Response storage: {err, data} per entry; data path is not reset.
   logic [DATA_W:0]  fifo_mem_p1 [DEPTH];
   logic [DATA_W:0]  head_p1;
   logic             vld_p1;

   logic req_fire;
   logic r_fire;
   logic push;
   logic pop;

   // Write-channel inputs are intentionally ignored.
   logic unused_wr_inputs;
   assign unused_wr_inputs = ^{awready, wready, bresp, bvalid};

   assign awaddr  = '0;
   assign awvalid = 1'b0;
   assign wdata   = '0;
   assign wstrb   = '0;
   assign wvalid  = 1'b0;
   assign bready  = 1'b0;

   // A slot is a credit whether the read is still on the bus or already
   // buffered, so the FIFO can never overflow with rready tied high.
   assign credits   = {1'b0, out_cnt} + {1'b0, fifo_cnt};
   assign req_ready = !flush && (!arvalid || arready) && (credits < CRED_MAX);
   assign req_fire  = req_valid && req_ready;
   assign r_fire    = rvalid && rready;
   assign push      = r_fire && !flush && (disc_cnt == '0);

   assign vld_p1     = (fifo_cnt != '0);
   assign head_p1    = fifo_mem_p1[rd_ptr];
   assign pop        = vld_p1 && resp_ready && !flush;
   assign resp_valid = vld_p1;
   assign resp_data  = vld_p1 ? head_p1[DATA_W-1:0] : '0;
   assign resp_err   = vld_p1 && head_p1[DATA_W];

   // Next in-flight count; flush blocks new requests, so at a flush this is
   // exactly the number of reads whose responses are still to arrive.
   always_comb begin
      out_nxt = out_cnt;
      if (req_fire) out_nxt = out_nxt + CNT_ONE;
      if (r_fire)   out_nxt = out_nxt - CNT_ONE;
   end

   // AR channel: load a new address on accept, hold it until arready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arvalid <= 1'b0;
         araddr  <= '0;
      end else if (req_fire) begin
         arvalid <= 1'b1;
         araddr  <= req_addr;
      end else if (arready) begin
         arvalid <= 1'b0;
      end
   end

   // R channel is always ready once out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rready <= 1'b0;
      else     rready <= 1'b1;
   end

   // In-flight and discard bookkeeping; a flush re-arms discard from the
   // live in-flight count so repeated flushes never double count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_cnt  <= '0;
         disc_cnt <= '0;
      end else begin
         out_cnt <= out_nxt;
         if (flush)
            disc_cnt <= out_nxt;
         else if (r_fire && (disc_cnt != '0))
            disc_cnt <= disc_cnt - CNT_ONE;
      end
   end

   // FIFO pointers and fill level; flush empties and ignores a same-cycle pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)
            fifo_cnt <= fifo_cnt + CNT_ONE;
         else if (pop && !push)
            fifo_cnt <= fifo_cnt - CNT_ONE;
      end
   end

   // ---- stage p1: capture returned beat into the response FIFO ----
   always_ff @(posedge clk) begin
      if (push) fifo_mem_p1[wr_ptr] <= {(rresp != 2'b00), rdata};
   end

`ifdef IFU_PERF_EN
   logic [63:0] perf_fetch_cnt;
   logic [63:0] perf_discard_cnt;
   logic [63:0] perf_ar_stall_cycles;
   logic [63:0] perf_full_cycles;
   logic [63:0] perf_flush_cnt;

   // Event counters for fetch efficiency analysis.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_cnt       <= '0;
         perf_discard_cnt     <= '0;
         perf_ar_stall_cycles <= '0;
         perf_full_cycles     <= '0;
         perf_flush_cnt       <= '0;
      end else begin
         if (push)                                perf_fetch_cnt       <= perf_fetch_cnt + 64'd1;
         if (r_fire && !push)                     perf_discard_cnt     <= perf_discard_cnt + 64'd1;
         if (arvalid && !arready)                 perf_ar_stall_cycles <= perf_ar_stall_cycles + 64'd1;
         if (req_valid && (credits == CRED_MAX))  perf_full_cycles     <= perf_full_cycles + 64'd1;
         if (flush)                               perf_flush_cnt       <= perf_flush_cnt + 64'd1;
      end
   end

   final begin
      $display("ifu_axi_prefetch perf: fetch=%0d discard=%0d ar_stall=%0d full=%0d flush=%0d",
               perf_fetch_cnt, perf_discard_cnt, perf_ar_stall_cycles,
               perf_full_cycles, perf_flush_cnt);
   end
`endif

endmodule

// File: tb/tb_ifu_axi_prefetch.sv
// Testbench for ifu_axi_prefetch: directed scenarios plus a randomized run,
// all checked against a queue-based model of accepted, flushed and returned fetches.
module tb_ifu_axi_prefetch;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                req_valid;
   logic                req_ready;
   logic [ADDR_W-1:0]   req_addr;
   logic                flush;
   logic                resp_valid;
   logic                resp_ready;
   logic [DATA_W-1:0]   resp_data;
   logic                resp_err;
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                bready;
   logic                awready = 1'b0;
   logic                wready  = 1'b0;
   logic [1:0]          bresp   = 2'b00;
   logic                bvalid  = 1'b0;
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   always #5 clk = ~clk;

   ifu_axi_prefetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .flush(flush),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_err(resp_err),
      .awaddr(awaddr), .awvalid(awvalid), .wdata(wdata), .wstrb(wstrb),
      .wvalid(wvalid), .bready(bready),
      .awready(awready), .wready(wready), .bresp(bresp), .bvalid(bvalid),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   int checks   = 0;
   int failures = 0;

   // Slave behaviour knobs
   bit ar_hold = 0;
   bit ar_rand = 0;
   bit r_en    = 0;
   bit r_rand  = 0;
   logic [ADDR_W-1:0] slave_q[$];

   // Reference model: fetches accepted but not yet returned (live = not flushed),
   // and returned fetches waiting to be consumed.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              live;
   } infl_t;
   infl_t            infl_q[$];
   logic [DATA_W:0]  buf_q[$];
   logic [DATA_W:0]  obs_q[$];
   logic [DATA_W:0]  exp_q[$];

   int mm_rdy = 0, mm_rv = 0, mm_wr = 0, mm_cred = 0;
   int ar_fires = 0, r_fires = 0;
   bit last_req_fire = 0;

   function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
      return ((a ^ 32'h8000_0000) * 32'd3) + 32'h0000_0413;
   endfunction

   function automatic logic [1:0] code_of(input logic [ADDR_W-1:0] a);
      if (a[11:8] == 4'hE) return 2'b10;
      if (a[11:8] == 4'hD) return 2'b11;
      return 2'b00;
   endfunction

   // One clock cycle: drive slave, observe handshakes, update model, go to next negedge.
   task automatic step();
      logic qf, af, rf, pf, ex_rdy;
      int   cred;
      infl_t h;
      arready = ar_hold ? 1'b0 : (ar_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      if (slave_q.size() != 0 && r_en && (!r_rand || $urandom_range(0, 1) == 1)) begin
         rvalid = 1'b1;
         rdata  = word_of(slave_q[0]);
         rresp  = code_of(slave_q[0]);
      end else begin
         rvalid = 1'b0;
         rdata  = $urandom;
         rresp  = 2'b00;
      end
      #1;
      if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0 ||
          awaddr !== '0 || wdata !== '0 || wstrb !== '0) mm_wr++;
      qf = req_valid && req_ready;
      af = arvalid && arready;
      rf = rvalid && rready;
      pf = resp_valid && resp_ready && !flush;
      last_req_fire = qf && !rst;
      if (!rst) begin
         cred   = infl_q.size() + buf_q.size();
         ex_rdy = !flush && (!arvalid || arready) && (cred < DEPTH);
         if (req_ready !== ex_rdy) mm_rdy++;
         if (resp_valid !== (buf_q.size() != 0)) mm_rv++;
         if (cred > DEPTH) mm_cred++;
         if (pf) begin
            obs_q.push_back({resp_err, resp_data});
            if (buf_q.size() != 0) exp_q.push_back(buf_q.pop_front());
            else                   exp_q.push_back('x);
         end
         if (rf) begin
            r_fires++;
            if (slave_q.size() != 0) void'(slave_q.pop_front());
            if (infl_q.size() != 0) begin
               h = infl_q.pop_front();
               if (h.live && !flush)
                  buf_q.push_back({(code_of(h.addr) != 2'b00), word_of(h.addr)});
            end
         end
         if (flush) begin
            buf_q.delete();
            foreach (infl_q[i]) infl_q[i].live = 1'b0;
         end
         if (af) begin
            ar_fires++;
            slave_q.push_back(araddr);
         end
         if (qf) infl_q.push_back('{addr: req_addr, live: 1'b1});
      end
      @(negedge clk);
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   // Present one request until accepted or the budget runs out.
   task automatic send(input logic [ADDR_W-1:0] a, input int budget, output bit ok);
      req_valid = 1'b1;
      req_addr  = a;
      ok        = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         step();
         ok = last_req_fire;
      end
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      step();
      step();
      checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid got=%b want=0", arvalid); end
      checks++; if (araddr !== '0) begin failures++; $display("FAIL reset_araddr got=%h want=0", araddr); end
      checks++; if (rready !== 1'b0) begin failures++; $display("FAIL reset_rready got=%b want=0", rready); end
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
      checks++; if (resp_err !== 1'b0 || resp_data !== '0) begin failures++; $display("FAIL reset_resp got=%b/%h want=0/0", resp_err, resp_data); end
      checks++; if ({awvalid, wvalid, bready} !== 3'b000 || awaddr !== '0 || wdata !== '0 || wstrb !== '0) begin
         failures++; $display("FAIL reset_write_idle got=%b%b%b %h %h %h want=all 0", awvalid, wvalid, bready, awaddr, wdata, wstrb);
      end
      rst = 1'b0;
      step();
      checks++; if (rready !== 1'b1) begin failures++; $display("FAIL rready_after_reset got=%b want=1", rready); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL req_ready_idle got=%b want=1", req_ready); end
   endtask

   task automatic test_single_fetch();
      bit ok;
      ar_hold = 0; ar_rand = 0; r_en = 1; r_rand = 0; resp_ready = 1'b0;
      obs_q.delete(); exp_q.delete();
      send(32'h8000_0000, 1, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_accept got=%b want=1", ok); end
      checks++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0000) begin
         failures++; $display("FAIL single_ar got=%b/%h want=1/80000000", arvalid, araddr);
      end
      step();
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b want=0", resp_valid); end
      step();
      checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL single_latency got=%b want=1", resp_valid); end
      checks++; if (resp_data !== 32'h0000_0413 || resp_err !== 1'b0) begin
         failures++; $display("FAIL single_data got=%h/%b want=00000413/0", resp_data, resp_err);
      end
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL single_pop got=%b want=0", resp_valid); end
   endtask

   task automatic test_pipelined();
      bit ok;
      int n_acc, late_fires;
      logic [DATA_W:0] want;
      resp_ready = 1'b0;
      obs_q.delete(); exp_q.delete();
      n_acc = 0;
      for (int k = 0; k < 4; k++) begin
         send(32'(k * 4), 4, ok);
         if (ok) n_acc++;
      end
      checks++; if (n_acc != 4) begin failures++; $display("FAIL pipe_accepts got=%0d want=4", n_acc); end
      req_valid = 1'b1; req_addr = 32'h10;
      #1;
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL pipe_full_ready got=%b want=0", req_ready); end
      late_fires = 0;
      repeat (6) begin step(); if (last_req_fire) late_fires++; end
      resp_ready = 1'b1;
      step();
      if (last_req_fire) late_fires++;
      resp_ready = 1'b0;
      checks++; if (late_fires != 0) begin failures++; $display("FAIL pipe_fifth_early got=%0d want=0", late_fires); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL pipe_ready_after_pop got=%b want=1", req_ready); end
      step();
      checks++; if (last_req_fire !== 1'b1) begin failures++; $display("FAIL pipe_fifth_accept got=%b want=1", last_req_fire); end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      run(10);
      checks++; if (obs_q.size() != 5) begin failures++; $display("FAIL pipe_count got=%0d want=5", obs_q.size()); end
      for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
         want = {1'b0, word_of(32'(i * 4))};
         checks++; if (obs_q[i] !== want) begin failures++; $display("FAIL pipe_order[%0d] got=%h want=%h", i, obs_q[i], want); end
      end
   endtask

   task automatic test_ar_backpressure();
      bit ok;
      int a0;
      resp_ready = 1'b1;
      obs_q.delete(); exp_q.delete();
      ar_hold = 1;
      a0 = ar_fires;
      send(32'h200, 1, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_accept got=%b want=1", ok); end
      req_valid = 1'b1; req_addr = 32'h204;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (arvalid !== 1'b1 || araddr !== 32'h200) begin
            failures++; $display("FAIL bp_hold[%0d] got=%b/%h want=1/00000200", i, arvalid, araddr);
         end
         checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%b want=0", i, req_ready); end
         step();
      end
      checks++; if (ar_fires != a0) begin failures++; $display("FAIL bp_no_handshake got=%0d want=0", ar_fires - a0); end
      ar_hold = 0;
      step();
      checks++; if (ar_fires - a0 != 1) begin failures++; $display("FAIL bp_one_handshake got=%0d want=1", ar_fires - a0); end
      checks++; if (last_req_fire !== 1'b1 || araddr !== 32'h204) begin
         failures++; $display("FAIL bp_b2b got=%b/%h want=1/00000204", last_req_fire, araddr);
      end
      req_valid = 1'b0;
      run(6);
      checks++; if (obs_q.size() != 2 || obs_q[0] !== {1'b0, word_of(32'h200)} || obs_q[1] !== {1'b0, word_of(32'h204)}) begin
         failures++; $display("FAIL bp_data got=%0d entries want=2 in order", obs_q.size());
      end
   endtask

   task automatic test_flush();
      bit ok;
      int r0;
      resp_ready = 1'b0; r_en = 1;
      obs_q.delete(); exp_q.delete();
      send(32'h300, 1, ok);
      run(2);
      checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL flush_buffered got=%b want=1", resp_valid); end
      r_en = 0;
      send(32'h304, 2, ok);
      send(32'h308, 2, ok);
      send(32'h30C, 2, ok);
      step();
      checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL flush_ar_done got=%b want=0", arvalid); end
      flush = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL flush_req_ready got=%b want=0", req_ready); end
      step();
      flush = 1'b0;
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got=%b want=0", resp_valid); end
      r0 = r_fires;
      r_en = 1; resp_ready = 1'b1;
      send(32'h100, 8, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL flush_new_accept got=%b want=1", ok); end
      run(12);
      checks++; if (r_fires - r0 != 4) begin failures++; $display("FAIL flush_beats got=%0d want=4", r_fires - r0); end
      checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL flush_count got=%0d want=1", obs_q.size()); end
      else if (obs_q[0] !== {1'b0, word_of(32'h100)}) begin
         failures++; $display("FAIL flush_data got=%h want=%h", obs_q[0], {1'b0, word_of(32'h100)});
      end
   endtask

   task automatic test_error();
      bit ok;
      resp_ready = 1'b1; r_en = 1;
      obs_q.delete(); exp_q.delete();
      send(32'hE00, 4, ok);
      send(32'h004, 4, ok);
      run(8);
      checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL err_count got=%0d want=2", obs_q.size()); end
      else begin
         checks++; if (obs_q[0] !== {1'b1, word_of(32'hE00)}) begin failures++; $display("FAIL err_slverr got=%h want=%h", obs_q[0], {1'b1, word_of(32'hE00)}); end
         checks++; if (obs_q[1] !== {1'b0, word_of(32'h004)}) begin failures++; $display("FAIL err_okay got=%h want=%h", obs_q[1], {1'b0, word_of(32'h004)}); end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int seen;
      resp_ready = 1'b0; r_en = 0;
      send(32'h400, 2, ok);
      send(32'h404, 2, ok);
      step();
      rst = 1'b1;
      #1;
      checks++; if (arvalid !== 1'b0 || araddr !== '0 || rready !== 1'b0) begin
         failures++; $display("FAIL midrst_ar got=%b/%h/%b want=0/0/0", arvalid, araddr, rready);
      end
      checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_data !== '0) begin
         failures++; $display("FAIL midrst_resp got=%b/%b/%h want=0/0/0", resp_valid, resp_err, resp_data);
      end
      slave_q.delete(); infl_q.delete(); buf_q.delete();
      run(2);
      rst = 1'b0;
      r_en = 1; resp_ready = 1'b1;
      obs_q.delete(); exp_q.delete();
      seen = 0;
      repeat (6) begin step(); if (resp_valid !== 1'b0) seen++; end
      checks++; if (seen != 0) begin failures++; $display("FAIL midrst_residual got=%0d want=0", seen); end
      send(32'h500, 4, ok);
      run(6);
      checks++; if (obs_q.size() != 1 || obs_q[0] !== {1'b0, word_of(32'h500)}) begin
         failures++; $display("FAIL midrst_new_fetch got=%0d entries want=1 matching", obs_q.size());
      end
   endtask

   task automatic test_random();
      int guard;
      obs_q.delete(); exp_q.delete();
      ar_rand = 1; r_rand = 1; r_en = 1;
      for (int c = 0; c < 800; c++) begin
         req_valid  = ($urandom_range(0, 2) != 0);
         req_addr   = $urandom & 32'hFFFF_FFFC;
         flush      = ($urandom_range(0, 24) == 0);
         resp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
      ar_rand = 0; r_rand = 0;
      guard = 0;
      while ((infl_q.size() != 0 || buf_q.size() != 0) && guard < 60) begin
         step();
         guard++;
      end
      checks++; if (infl_q.size() != 0 || buf_q.size() != 0) begin
         failures++; $display("FAIL rand_drain got=%0d/%0d pending want=0/0", infl_q.size(), buf_q.size());
      end
      checks++; if (obs_q.size() != exp_q.size() || obs_q.size() == 0) begin
         failures++; $display("FAIL rand_count got=%0d want=%0d (nonzero)", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_data[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
      end
      checks++; if (mm_rdy != 0) begin failures++; $display("FAIL req_ready_tracking got=%0d bad cycles want=0", mm_rdy); end
      checks++; if (mm_rv != 0) begin failures++; $display("FAIL resp_valid_tracking got=%0d bad cycles want=0", mm_rv); end
      checks++; if (mm_cred != 0) begin failures++; $display("FAIL credit_bound got=%0d bad cycles want=0", mm_cred); end
      checks++; if (mm_wr != 0) begin failures++; $display("FAIL write_idle got=%0d bad cycles want=0", mm_wr); end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_addr = '0; flush = 1'b0; resp_ready = 1'b0;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      @(negedge clk);
      test_reset();
      test_single_fetch();
      test_pipelined();
      test_ar_backpressure();
      test_flush();
      test_error();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ifu_axi_prefetch.md
Name: ifu_axi_prefetch

Overview:
- Parametrised instruction-fetch AXI4-Lite read master.
- Sits between the IF stage and the AXI arbiter/crossbar.
- Accepts fetch addresses on a valid/ready request port and keeps up to DEPTH reads in flight.
- Buffers returned instructions in an in-order response FIFO and supports a pipeline flush that discards stale in-flight responses.
- Write channels exist for bus uniformity and are permanently idle.

Parameters:
- ADDR_W, 32, address width of req_addr/araddr/awaddr.
- DATA_W, 32, instruction/data width of rdata/resp_data/wdata.
- DEPTH, 4, max outstanding reads plus buffered responses; power of 2, >=2.
- CNT_W, $clog2(DEPTH)+1, width of the internal occupancy/credit counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  fetch request valid
- req_ready  out  1  fetch request accepted this cycle when req_valid=1
- req_addr  in  ADDR_W  fetch address
- flush  in  1  one-cycle pulse: drop all pending/buffered fetches
- resp_valid  out  1  instruction available
- resp_ready  in  1  consumer takes instruction
- resp_data  out  DATA_W  instruction word
- resp_err  out  1  rresp was non-OKAY
- awaddr/awvalid/wdata/wstrb/wvalid/bready  out  ADDR_W/1/DATA_W/DATA_W/8/1/1  write channels, tied idle
- awready/wready/bresp/bvalid  in  1/1/2/1  ignored
- araddr  out  ADDR_W  read address
- arvalid  out  1  read address valid
- arready  in  1  read address ready
- rdata  in  DATA_W  read data
- rresp  in  2  read response
- rvalid  in  1  read data valid
- rready  out  1  read data ready

Behaviour:
- Reset values:
  - araddr, arvalid, rready, resp_valid, resp_err = 0; resp_data = 0 while FIFO empty.
  - All write-channel outputs = 0 in every cycle.
  - FIFO pointers, outstanding counter and discard counter = 0.
- Reset mid-operation clears all state immediately. No residual beat is delivered.
- credits = outstanding (AR accepted or pending, R not yet received) + FIFO count. credits is never > DEPTH.
- req_ready = !flush && (!arvalid || arready) && credits < DEPTH.
  - Combinational; independent of req_valid.
- On request accept at edge N: araddr <= req_addr, arvalid <= 1, outstanding increments.
- arvalid is held with a stable araddr until arready is sampled high.
  - If a new request is accepted in the same cycle as the arready handshake, arvalid stays 1 with the new address (back-to-back issue, 1 AR per cycle).
- rready = 1 every cycle after reset. The credit scheme guarantees FIFO space.
- On an R beat (rvalid && rready):
  - outstanding decrements.
  - If discard > 0: beat dropped, discard decrements.
  - Otherwise {rresp!=2'b00, rdata} is pushed to the FIFO.
- resp_valid = FIFO non-empty; resp_data/resp_err come from the registered FIFO head. Pop on resp_valid && resp_ready.
- Push and pop in the same cycle: count unchanged, ordering preserved.
- Minimum latency: accept at edge N -> arvalid high cycle N+1 -> rvalid at N+2 -> resp_valid high in cycle N+3.
- Flush at edge F:
  - FIFO is emptied; a same-cycle pop is ignored.
  - discard <= outstanding after this cycle's R beat. A same-cycle R beat is itself dropped.
  - A pending AR is not withdrawn; its response is discarded.
  - req_ready = 0 during the flush cycle.
  - Back-to-back flushes recompute discard from the current outstanding count (no double counting).
- Out-of-order R data is not supported; the AXI slave returns reads in order.

Optional Feature:
- Macro: IFU_PERF_EN.
- Defined: 64-bit internal counters, all cleared by rst:
  - perf_fetch_cnt: FIFO pushes.
  - perf_discard_cnt: discarded beats.
  - perf_ar_stall_cycles: arvalid && !arready.
  - perf_full_cycles: req_valid && credits==DEPTH.
  - perf_flush_cnt: flush pulses.
- Defined also: a $display summary when the simulation finishes.
- Undefined: none of these counters exist, and the port list and timing are identical.

Test Plan:
- Single fetch: req_addr=0x8000_0000, arready=1, slave returns 0x00000413 one cycle later -> araddr=0x8000_0000, resp_valid in cycle N+3, resp_data=0x00000413, resp_err=0.
- Pipelined: 4 requests at 0x0,0x4,0x8,0xC, resp_ready=0 -> req_ready drops after 4th (credits=4); releasing resp_ready returns data in order. A 5th request is accepted one cycle after the first pop.
- AR backpressure: arready=0 for 3 cycles -> arvalid held and araddr stable; req_ready=0; exactly one AR handshake occurs.
- Flush: 3 outstanding, 1 buffered, flush pulse -> FIFO empties; next 3 R beats are dropped. A request to 0x100 issued after the flush yields only its own data.
- Error: rresp=2'b10 -> resp_err=1 with that word. The next OKAY beat gives resp_err=0.
- Reset mid-operation: assert rst with 2 outstanding -> all outputs at reset values; resp_valid stays 0 after release until a new fetch completes.
